// File: rtl/cnn_pkg.sv
// Shared fixed-point constants and the error-readout state encoding for the CNN datapath.
package cnn_pkg;

   localparam int WORD_W    = 16;
   localparam int FRAC_BITS = 10;

   localparam logic [WORD_W-1:0] Q_MAX = 16'h7FFF;
   localparam logic [WORD_W-1:0] Q_MIN = 16'h8000;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_CAP  = 3'd2,
      ST_OUT  = 3'd3,
      ST_CLR  = 3'd4
   } rd_state_t;

endpackage

// File: rtl/q10_mul_sat.sv
// Signed Q6.10 multiply: full 32-bit product, arithmetic shift by FRAC_BITS, saturate to 16 bits.
module q10_mul_sat
   import cnn_pkg::*;
(
   input  logic signed [WORD_W-1:0] a,
   input  logic signed [WORD_W-1:0] b,
   output logic signed [WORD_W-1:0] y
);

   localparam logic signed [2*WORD_W-1:0] SAT_HI = 32'sd32767;
   localparam logic signed [2*WORD_W-1:0] SAT_LO = -32'sd32768;

   logic signed [2*WORD_W-1:0] prod;
   logic signed [2*WORD_W-1:0] sh;

   // NOTE: y is assigned on every path, so no latch is inferred.
   always_comb begin
      prod = a * b;
      sh   = prod >>> FRAC_BITS;
      if (sh > SAT_HI)
         y = Q_MAX;
      else if (sh < SAT_LO)
         y = Q_MIN;
      else
         y = sh[WORD_W-1:0];
   end

endmodule

// File: rtl/err_readout.sv
// Output-layer error reader: walks the accumulated-error words in RAM, scales them by lr and
// streams them to the weight-update stage, optionally zeroing each word once it has been taken.
module err_readout
   import cnn_pkg::*;
#(
   parameter int BCK_CELL         = 10,
   parameter int ERR_BASE         = 10,
   parameter bit CLEAR_AFTER_READ = 1'b1
)(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              error_end,
   input  logic [WORD_W-1:0] lr,
   output logic              mem_req,
   output logic [WORD_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [WORD_W-1:0] mem_data,
   input  logic [WORD_W-1:0] mem_q,
   output logic              delta_valid,
   input  logic              delta_ready,
   output logic [WORD_W-1:0] delta_data,
   output logic [WORD_W-1:0] delta_idx,
   output logic              delta_last,
   output logic              done,
   output logic              overrun
);

   rd_state_t         state;
   logic [WORD_W-1:0] idx;
   logic [WORD_W-1:0] lr_q;
   logic              end_q;
   logic              rise;
   logic              last_cell;
   logic [WORD_W-1:0] delta_nxt;

   assign rise      = error_end & ~end_q;
   assign last_cell = (idx == WORD_W'(BCK_CELL - 1));

   q10_mul_sat u_mul (
      .a (mem_q),
      .b (lr_q),
      .y (delta_nxt)
   );

   // RAM controls decode straight from state, so an async reset drops mem_we in the same instant.
   assign mem_req  = (state != ST_IDLE);
   assign mem_addr = mem_req ? (WORD_W'(ERR_BASE) + idx) : '0;
   assign mem_we   = (state == ST_CLR);
   assign mem_data = '0;

   // NOTE: all state here uses non-blocking assignments so every read sees pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         idx         <= '0;
         lr_q        <= '0;
         end_q       <= 1'b0;
         delta_valid <= 1'b0;
         delta_data  <= '0;
         delta_idx   <= '0;
         delta_last  <= 1'b0;
         done        <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         end_q <= error_end;
         done  <= 1'b0;
         // The cycle carrying done still counts as busy for a new start request.
         if (rise && (state != ST_IDLE || done))
            overrun <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (rise && !done) begin
                  idx   <= '0;
                  lr_q  <= lr;
                  state <= ST_RD;
               end
            end
            ST_RD: state <= ST_CAP;
            ST_CAP: begin
               delta_data  <= delta_nxt;
               delta_idx   <= idx;
               delta_last  <= last_cell;
               delta_valid <= 1'b1;
               state       <= ST_OUT;
            end
            ST_OUT: begin
               if (delta_ready) begin
                  delta_valid <= 1'b0;
                  if (CLEAR_AFTER_READ) begin
                     state <= ST_CLR;
                  end else if (last_cell) begin
                     done  <= 1'b1;
                     state <= ST_IDLE;
                  end else begin
                     idx   <= idx + 1'b1;
                     state <= ST_RD;
                  end
               end
            end
            ST_CLR: begin
               if (last_cell) begin
                  done  <= 1'b1;
                  state <= ST_IDLE;
               end else begin
                  idx   <= idx + 1'b1;
                  state <= ST_RD;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_err_readout.sv
// Directed bench for err_readout: one clearing instance and one non-clearing instance, each with a RAM model.
module tb_err_readout;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        error_end = 1'b0;
   logic        error_end_b = 1'b0;
   logic [15:0] lr = '0;
   logic        ready_a = 1'b1;
   logic        ready_b = 1'b1;

   logic        a_req, a_we, a_valid, a_last, a_done, a_ovr;
   logic [15:0] a_addr, a_wdata, a_q, a_data, a_idx;
   logic        b_req, b_we, b_valid, b_last, b_done, b_ovr;
   logic [15:0] b_addr, b_wdata, b_q, b_data, b_idx;

   logic [15:0] mem_a [0:63];
   logic [15:0] mem_b [0:63];
   logic        pre_we = 1'b0;
   logic        pre_sel = 1'b0;
   logic [5:0]  pre_addr = '0;
   logic [15:0] pre_data = '0;

   int          checks = 0;
   int          errors = 0;
   int          b_we_cnt = 0;
   logic        use_b = 1'b0;
   logic [15:0] src   [10];
   logic [15:0] exp_d [10];

   logic        v_req, v_we, v_valid, v_last, v_done;
   logic [15:0] v_data, v_idx;

   always #5 clk = ~clk;

   err_readout #(.BCK_CELL(10), .ERR_BASE(10), .CLEAR_AFTER_READ(1'b1)) u_dut (
      .clk(clk), .reset_n(reset_n), .error_end(error_end), .lr(lr),
      .mem_req(a_req), .mem_addr(a_addr), .mem_we(a_we), .mem_data(a_wdata), .mem_q(a_q),
      .delta_valid(a_valid), .delta_ready(ready_a), .delta_data(a_data), .delta_idx(a_idx),
      .delta_last(a_last), .done(a_done), .overrun(a_ovr)
   );

   err_readout #(.BCK_CELL(10), .ERR_BASE(10), .CLEAR_AFTER_READ(1'b0)) u_dut_nc (
      .clk(clk), .reset_n(reset_n), .error_end(error_end_b), .lr(lr),
      .mem_req(b_req), .mem_addr(b_addr), .mem_we(b_we), .mem_data(b_wdata), .mem_q(b_q),
      .delta_valid(b_valid), .delta_ready(ready_b), .delta_data(b_data), .delta_idx(b_idx),
      .delta_last(b_last), .done(b_done), .overrun(b_ovr)
   );

   always @(posedge clk) begin
      if (pre_we && !pre_sel) mem_a[pre_addr] <= pre_data;
      else if (a_we)          mem_a[a_addr[5:0]] <= a_wdata;
      a_q <= mem_a[a_addr[5:0]];
   end

   always @(posedge clk) begin
      if (pre_we && pre_sel) mem_b[pre_addr] <= pre_data;
      else if (b_we)         mem_b[b_addr[5:0]] <= b_wdata;
      b_q <= mem_b[b_addr[5:0]];
      if (b_we) b_we_cnt <= b_we_cnt + 1;
   end

   assign v_req   = use_b ? b_req   : a_req;
   assign v_we    = use_b ? b_we    : a_we;
   assign v_valid = use_b ? b_valid : a_valid;
   assign v_last  = use_b ? b_last  : a_last;
   assign v_done  = use_b ? b_done  : a_done;
   assign v_data  = use_b ? b_data  : a_data;
   assign v_idx   = use_b ? b_idx   : a_idx;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic load_src(input logic sel);
      for (int i = 0; i < 10; i++) begin
         pre_sel  = sel;
         pre_addr = 6'(10 + i);
         pre_data = src[i];
         pre_we   = 1'b1;
         @(posedge clk);
         #1 pre_we = 1'b0;
      end
   endtask

   // Starts a pass on the selected instance and checks every beat plus the done timing.
   task automatic run_pass(input int exp_cycles, input int stall_at, input int ovr_at);
      int cyc;
      int k;
      bit seen_done;
      @(posedge clk);
      #1;
      if (use_b) error_end_b = 1'b1; else error_end = 1'b1;
      @(posedge clk);
      #1;
      error_end = 1'b0;
      error_end_b = 1'b0;
      lr = 16'h0001;
      check("req_at_start", 32'(v_req), 32'd1);
      cyc = 0;
      k = 0;
      seen_done = 1'b0;
      while (cyc < exp_cycles + 20 && !seen_done) begin
         @(posedge clk);
         #1;
         error_end = 1'b0;
         error_end_b = 1'b0;
         cyc++;
         if (v_valid && k < 10) begin
            if (k == 0) check("first_valid_cycle", 32'(cyc), 32'd2);
            check("delta_data", 32'(v_data), 32'(exp_d[k]));
            check("delta_idx", 32'(v_idx), 32'(k));
            check("delta_last", 32'(v_last), 32'(k == 9));
            if (k == stall_at) begin
               ready_a = 1'b0;
               repeat (5) begin
                  @(posedge clk);
                  #1;
                  cyc++;
                  check("stall_valid", 32'(v_valid), 32'd1);
                  check("stall_data", 32'(v_data), 32'(exp_d[k]));
                  check("stall_idx", 32'(v_idx), 32'(k));
                  check("stall_we", 32'(v_we), 32'd0);
                  check("stall_mem", 32'(mem_a[10 + k]), 32'(src[k]));
               end
               ready_a = 1'b1;
            end
            if (k == ovr_at) begin
               if (use_b) error_end_b = 1'b1; else error_end = 1'b1;
            end
            k++;
         end
         if (v_done) begin
            seen_done = 1'b1;
            check("done_cycle", 32'(cyc), 32'(exp_cycles));
            check("beat_count", 32'(k), 32'd10);
         end
      end
      if (!seen_done) check("done_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      bit found;
      int extra;

      #2 reset_n = 1'b0;
      #2;
      check("rst_ctl", {26'd0, a_req, a_we, a_valid, a_last, a_done, a_ovr}, 32'd0);
      check("rst_addr", 32'(a_addr), 32'd0);
      check("rst_wdata", 32'(a_wdata), 32'd0);
      check("rst_data", 32'(a_data), 32'd0);
      check("rst_idx", 32'(a_idx), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 reset_n = 1'b1;

      // Unity learning rate, clearing instance.
      src = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005,
              16'h0006, 16'h0007, 16'h0008, 16'h0009, 16'h000A};
      load_src(1'b0);
      exp_d = src;
      lr = 16'h0400;
      run_pass(40, -1, -1);
      for (int i = 0; i < 10; i++) check("cleared", 32'(mem_a[10 + i]), 32'd0);

      // Half learning rate with negative values and a 5-cycle stall at idx 3.
      src   = '{16'h0600, 16'hFFFF, 16'h0001, 16'hFC00, 16'h7FFF,
                16'h8000, 16'h0003, 16'hFFFD, 16'h0400, 16'h0002};
      exp_d = '{16'h0300, 16'hFFFF, 16'h0000, 16'hFE00, 16'h3FFF,
                16'hC000, 16'h0001, 16'hFFFE, 16'h0200, 16'h0001};
      load_src(1'b0);
      lr = 16'h0200;
      run_pass(45, 3, -1);
      check("cleared_13", 32'(mem_a[13]), 32'd0);

      // Learning rate 2.0, saturation boundaries.
      src   = '{16'h7FFF, 16'h8000, 16'h4000, 16'h3FFF, 16'hC000,
                16'hBFFF, 16'h0001, 16'hFFFF, 16'h0000, 16'h1234};
      exp_d = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h7FFE, 16'h8000,
                16'h8000, 16'h0002, 16'hFFFE, 16'h0000, 16'h2468};
      load_src(1'b0);
      lr = 16'h0800;
      run_pass(40, -1, -1);
      check("no_overrun_a", 32'(a_ovr), 32'd0);

      // Non-clearing instance with a second start edge at idx 5.
      use_b = 1'b1;
      src = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055,
              16'h0066, 16'h0077, 16'h0088, 16'h0099, 16'h00AA};
      load_src(1'b1);
      exp_d = src;
      lr = 16'h0400;
      run_pass(30, -1, 5);
      check("overrun_b", 32'(b_ovr), 32'd1);
      check("no_write_b", 32'(b_we_cnt), 32'd0);
      check("mem_b_kept", 32'(mem_b[19]), 32'h00AA);
      extra = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (b_req) extra++;
      end
      check("no_second_pass", 32'(extra), 32'd0);
      use_b = 1'b0;

      // Reset asserted while clearing cell 2.
      src = '{16'h0005, 16'h0006, 16'h0007, 16'h0008, 16'h0009,
              16'h000A, 16'h000B, 16'h000C, 16'h000D, 16'h000E};
      load_src(1'b0);
      lr = 16'h0400;
      @(posedge clk);
      #1 error_end = 1'b1;
      @(posedge clk);
      #1 error_end = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (a_we && a_addr == 16'd12) found = 1'b1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      check("reached_clr_2", 32'(found), 32'd1);
      reset_n = 1'b0;
      #1;
      check("mid_rst_ctl", {27'd0, a_req, a_we, a_valid, a_last, a_done}, 32'd0);
      check("mid_rst_addr", 32'(a_addr), 32'd0);
      check("mid_rst_data", 32'(a_data), 32'd0);
      check("mid_rst_idx", 32'(a_idx), 32'd0);
      @(posedge clk);
      #1;
      check("mem12_kept", 32'(mem_a[12]), 32'h0007);
      check("mem11_cleared", 32'(mem_a[11]), 32'd0);
      reset_n = 1'b1;
      for (int i = 0; i < 10; i++) exp_d[i] = (i < 2) ? 16'h0000 : src[i];
      run_pass(40, -1, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/err_readout.md
# err_readout

Back-propagation error reader for the output layer. On a rising edge of `error_end`, it walks the BCK_CELL accumulated-error words held in the output-layer RAM, scales each by a Q6.10 learning rate with saturation, and streams the result with a valid/ready handshake to the weight-update stage. It can optionally zero each accumulator after it has been consumed. It sits between the output-layer RAM (it shares that RAM's port through `mem_req`) and the weight-update logic.

## Interface
- BCK_CELL, 10, number of output cells (error words per pass)
- ERR_BASE, 10, RAM address of accumulated error for cell 0
- CLEAR_AFTER_READ, 1, 1 = write 0 to each accumulator after its handshake
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- error_end  in  1  from the RAM block; a rising edge starts one pass
- lr  in  16  signed Q6.10 learning rate, sampled at pass start
- mem_req  out  1  high while a pass is active; the top-level mux grants the RAM port
- mem_addr  out  16  RAM address
- mem_we  out  1  RAM write enable
- mem_data  out  16  RAM write data (always 0)
- mem_q  in  16  RAM read data, valid one cycle after the address edge
- delta_valid  out  1  scaled error available
- delta_ready  in  1  downstream accepts
- delta_data  out  16  signed Q6.10 scaled error
- delta_idx  out  16  cell index 0..BCK_CELL-1
- delta_last  out  1  high with the index BCK_CELL-1 beat
- done  out  1  one-cycle pulse at end of pass
- overrun  out  1  sticky; an `error_end` rising edge arrived while busy

## Operation
- States: IDLE, RD, CAP, OUT, CLR.
- IDLE:
  - Rising edge of `error_end` (compared with a registered copy): idx←0, lr_q←lr, →RD.
  - Otherwise stay.
- RD: `mem_addr` = ERR_BASE+idx, `mem_we`=0. →CAP.
- CAP: capture `mem_q` as err. Compute delta. Load `delta_data`/`delta_idx`/`delta_last`, set `delta_valid`. →OUT.
- OUT: hold all delta outputs stable until `delta_valid && delta_ready`. On handshake, clear `delta_valid`.
  - If CLEAR_AFTER_READ: →CLR.
  - Else if idx==BCK_CELL-1: pulse `done`, →IDLE.
  - Else idx++, →RD.
- CLR: `mem_we`=1, `mem_addr`=ERR_BASE+idx, `mem_data`=0.
  - If idx==BCK_CELL-1: pulse `done`, →IDLE.
  - Else idx++, →RD.
- `mem_req` is high in every state except IDLE. `mem_addr` = ERR_BASE+idx whenever `mem_req`=1, and 0 otherwise.
- Arithmetic:
  - prod = signed(err) × signed(lr_q), 32-bit.
  - sh = prod >>> 10 (arithmetic shift, rounds toward −∞).
  - delta = sh saturated to [0x8000, 0x7FFF].
- A rising edge of `error_end` outside IDLE is ignored and sets `overrun`. `overrun` is cleared only by reset.
- `lr` changes mid-pass have no effect.

## Timing
- Reset values:
  - State IDLE, idx 0.
  - `mem_req`, `mem_we`, `delta_valid`, `delta_last`, `done`, `overrun` all 0.
  - `mem_addr`, `mem_data`, `delta_data`, `delta_idx` all 0.
  - `error_end` history register 0.
- Start latency: the edge sampling `error_end`=1 (previous sample 0) moves the block to RD. `delta_valid` rises 2 edges later.
- Throughput with `delta_ready` tied high: 4 cycles per cell with clear, 3 without. A full pass is 4·BCK_CELL cycles from RD entry to `done`.
- `done` is asserted in the cycle after the last CLR (or last OUT handshake when not clearing), concurrent with returning to IDLE.
- A new rising edge of `error_end` in the same cycle `done` is high is treated as busy: it is ignored and sets `overrun`.
- Reset asserted mid-pass: all outputs return to reset values immediately, with no partial write issued. Memory contents are left as they stand.
- No RAM write ever occurs for a cell before its delta handshake.

## Structure
- Shared package `cnn_pkg`:
  - WORD_W=16, FRAC_BITS=10.
  - Q_MAX=16'h7FFF, Q_MIN=16'h8000.
  - The readout state enum.
- Sub-module `q10_mul_sat`: combinational signed 16×16 multiply, >>>FRAC_BITS, saturate to 16 bits. It is reused by the weight-update stage.

## Test plan
- lr=0x0400 (1.0), mem[10..19]=0x0001..0x000A, ready=1 → deltas 0x0001..0x000A, idx 0..9, `delta_last` on idx 9, `done` 40 cycles after RD entry, mem[10..19]=0 afterwards.
- lr=0x0200 (0.5), err=0x0600 → delta 0x0300. err=0xFFFF → delta 0xFFFF (−∞ rounding).
- Saturation: lr=0x0800 (2.0), err=0x7FFF → 0x7FFF; err=0x8000 → 0x8000.
- Backpressure: `delta_ready` low for 5 cycles at idx 3 → `delta_data`/`delta_idx` stable, `mem_we` stays 0, mem[13] unchanged until the handshake.
- Second `error_end` rising edge at idx 5 → pass completes normally, `overrun`=1, no second pass. CLEAR_AFTER_READ=0 → no `mem_we` pulse at all, 30-cycle pass.
- `reset_n` pulsed low while in CLR at idx 2 → outputs at reset values, mem[12] keeps its value, the next `error_end` edge restarts at idx 0.
